// File: rtl/key_entry_acc.sv
// Keypad entry accumulator: edits an up-to-DIGITS decimal entry from key
// strobes and, on ENTER, converts the BCD entry to binary MSD first.
module key_entry_acc #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned DW      = 10,
  parameter logic [3:0]  KEY_BS  = 4'hB,
  parameter logic [3:0]  KEY_CLR = 4'hC,
  parameter logic [3:0]  KEY_ENT = 4'hE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     din,
  input  logic                           din_vld,
  output logic [DW-1:0]                  dout,
  output logic                           dout_vld,
  output logic [4*DIGITS-1:0]            bcd,
  output logic [$clog2(DIGITS+1)-1:0]    dig_cnt,
  output logic                           busy,
  output logic                           ovf
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e          state_q,    state_d;
  logic [BW-1:0]   bcd_q,      bcd_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [BW-1:0]   shadow_q,   shadow_d;
  logic [DW-1:0]   acc_q,      acc_d;
  logic [IW-1:0]   idx_q,      idx_d;
  logic [DW-1:0]   dout_q,     dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic            ovf_q,      ovf_d;

  logic [3:0]      digit;
  logic [DW-1:0]   acc_mul10;
  logic [DW-1:0]   acc_nxt;

  // Multiply-by-ten as shift-add, then fold in the digit selected by idx_q.
  always_comb begin
    digit     = 4'(shadow_q >> {idx_q, 2'b00});
    acc_mul10 = (acc_q << 3) + (acc_q << 1);
    acc_nxt   = acc_mul10 + DW'(digit);
  end

  // Next-state and output decode; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_vld) begin
          if (din <= 4'd9) begin
            if (cnt_q < CW'(DIGITS)) begin
              bcd_d = BW'({bcd_q, din});
              cnt_d = cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (din == KEY_BS) begin
            if (cnt_q != '0) begin
              bcd_d = bcd_q >> 4;
              cnt_d = cnt_q - CW'(1);
            end
          end else if (din == KEY_CLR) begin
            bcd_d = '0;
            cnt_d = '0;
          end else if (din == KEY_ENT) begin
            state_d  = CONV;
            acc_d    = '0;
            idx_d    = IW'(DIGITS - 1);
            shadow_d = bcd_q;
          end
        end
      end
      CONV: begin
        acc_d = acc_nxt;
        if (idx_q == '0) begin
          dout_d     = acc_nxt;
          dout_vld_d = 1'b1;
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign bcd      = bcd_q;
  assign dig_cnt  = cnt_q;
  assign busy     = (state_q == CONV);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_entry_acc.sv
// Bench for key_entry_acc: behavioural model plus scoreboard of conversion results.
module tb_key_entry_acc;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned DW     = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  din;
  logic        din_vld;
  logic [9:0]  dout;
  logic        dout_vld;
  logic [11:0] bcd;
  logic [1:0]  dig_cnt;
  logic        busy;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  // model state
  logic [11:0] m_bcd;
  logic [1:0]  m_cnt;
  int          m_busy;
  logic        m_vld;
  logic        m_ovf;
  logic        mon_en = 1'b0;
  int          exp_q[$];

  key_entry_acc #(.DIGITS(DIGITS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .bcd(bcd), .dig_cnt(dig_cnt),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Per-cycle checker against the model; pops the scoreboard on each result pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (dout_vld !== m_vld) begin
        fails++; $display("FAIL mon_dout_vld got %b exp %b at %0t", dout_vld, m_vld, $time);
      end
      tests++;
      if (ovf !== m_ovf) begin
        fails++; $display("FAIL mon_ovf got %b exp %b at %0t", ovf, m_ovf, $time);
      end
      tests++;
      if (bcd !== m_bcd || dig_cnt !== m_cnt) begin
        fails++; $display("FAIL mon_entry got bcd=%h cnt=%0d exp bcd=%h cnt=%0d at %0t",
                          bcd, dig_cnt, m_bcd, m_cnt, $time);
      end
      tests++;
      if (busy !== (m_busy > 0)) begin
        fails++; $display("FAIL mon_busy got %b exp %b at %0t", busy, (m_busy > 0), $time);
      end
      if (dout_vld === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL sb_dout got %0d exp <none> at %0t", dout, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (dout !== 10'(e)) begin
            fails++; $display("FAIL sb_dout got %0d exp %0d at %0t", dout, e, $time);
          end
        end
      end
    end
  end

  // One clock of stimulus from a negedge to the next; model advances at the posedge.
  task automatic step(input logic v, input logic [3:0] k);
    din     = k;
    din_vld = v;
    @(posedge clk);
    m_vld = 1'b0;
    m_ovf = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_vld = 1'b1;
        m_bcd = '0;
        m_cnt = '0;
      end
    end else if (v) begin
      if (k <= 4'd9) begin
        if (m_cnt < 2'd3) begin
          m_bcd = {m_bcd[7:0], k};
          m_cnt = m_cnt + 2'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (k == 4'hB) begin
        if (m_cnt != 2'd0) begin
          m_bcd = {4'h0, m_bcd[11:4]};
          m_cnt = m_cnt - 2'd1;
        end
      end else if (k == 4'hC) begin
        m_bcd = '0;
        m_cnt = '0;
      end else if (k == 4'hE) begin
        exp_q.push_back(int'(m_bcd[11:8]) * 100 + int'(m_bcd[7:4]) * 10 + int'(m_bcd[3:0]));
        m_busy = DIGITS;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'($urandom));
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k);
    idle($urandom_range(0, 2));
  endtask

  task automatic model_reset();
    m_bcd = '0; m_cnt = '0; m_busy = 0; m_vld = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Assert reset just after a negedge, hold two cycles, release away from posedge.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    mon_en = 1'b1;
    tests++;
    if (dout !== 10'd0 || dout_vld !== 1'b0 || bcd !== 12'h0 || dig_cnt !== 2'd0 ||
        busy !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL reset_state got dout=%0d vld=%b bcd=%h cnt=%0d busy=%b ovf=%b exp all 0",
                        dout, dout_vld, bcd, dig_cnt, busy, ovf);
    end
  endtask

  task automatic test_basic();
    key(4'd1); key(4'd2); key(4'd3);
    tests++;
    if (bcd !== 12'h123) begin
      fails++; $display("FAIL basic_bcd got %h exp 123", bcd);
    end
    step(1'b1, 4'hE);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    tests++;
    if (dout_vld !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_pre_pulse got vld=%b busy=%b exp vld=0 busy=1", dout_vld, busy);
    end
    step(1'b0, 4'h0);
    tests++;
    if (dout_vld !== 1'b1 || dout !== 10'd123) begin
      fails++; $display("FAIL basic_result got vld=%b dout=%0d exp vld=1 dout=123", dout_vld, dout);
    end
    step(1'b0, 4'h0);
    tests++;
    if (dout_vld !== 1'b0 || dout !== 10'd123 || bcd !== 12'h0 || dig_cnt !== 2'd0) begin
      fails++; $display("FAIL basic_after got vld=%b dout=%0d bcd=%h cnt=%0d exp 0/123/0/0",
                        dout_vld, dout, bcd, dig_cnt);
    end
  endtask

  task automatic test_ovf();
    key(4'd9); key(4'd8); key(4'd7);
    step(1'b1, 4'd6);
    tests++;
    if (ovf !== 1'b1 || bcd !== 12'h987 || dig_cnt !== 2'd3) begin
      fails++; $display("FAIL ovf_pulse got ovf=%b bcd=%h cnt=%0d exp 1/987/3", ovf, bcd, dig_cnt);
    end
    step(1'b0, 4'd5);
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_single got %b exp 0", ovf);
    end
    step(1'b1, 4'hE);
    idle(4);
    tests++;
    if (dout !== 10'd987) begin
      fails++; $display("FAIL ovf_dout got %0d exp 987", dout);
    end
  endtask

  task automatic test_backspace();
    step(1'b1, 4'hB);
    tests++;
    if (bcd !== 12'h0 || dig_cnt !== 2'd0) begin
      fails++; $display("FAIL bs_empty got bcd=%h cnt=%0d exp 0/0", bcd, dig_cnt);
    end
    key(4'd4); key(4'd5);
    tests++;
    if (bcd !== 12'h045) begin
      fails++; $display("FAIL bs_045 got %h exp 045", bcd);
    end
    key(4'hB);
    tests++;
    if (bcd !== 12'h004 || dig_cnt !== 2'd1) begin
      fails++; $display("FAIL bs_004 got bcd=%h cnt=%0d exp 004/1", bcd, dig_cnt);
    end
    key(4'd7);
    tests++;
    if (bcd !== 12'h047) begin
      fails++; $display("FAIL bs_047 got %h exp 047", bcd);
    end
    step(1'b1, 4'hE);
    idle(4);
    tests++;
    if (dout !== 10'd47) begin
      fails++; $display("FAIL bs_dout got %0d exp 47", dout);
    end
  endtask

  task automatic test_clear_ignored();
    key(4'd5); key(4'hA); key(4'hD);
    tests++;
    if (bcd !== 12'h005 || dig_cnt !== 2'd1) begin
      fails++; $display("FAIL ign_keys got bcd=%h cnt=%0d exp 005/1", bcd, dig_cnt);
    end
    key(4'hC); key(4'hF);
    tests++;
    if (bcd !== 12'h0 || dig_cnt !== 2'd0) begin
      fails++; $display("FAIL clr got bcd=%h cnt=%0d exp 0/0", bcd, dig_cnt);
    end
    step(1'b1, 4'hE);
    idle(2);
    step(1'b0, 4'h0);
    tests++;
    if (dout_vld !== 1'b1 || dout !== 10'd0) begin
      fails++; $display("FAIL empty_enter got vld=%b dout=%0d exp 1/0", dout_vld, dout);
    end
    idle(1);
  endtask

  task automatic test_busy_drop();
    key(4'd9); key(4'd9); key(4'd9);
    step(1'b1, 4'hE);
    step(1'b1, 4'd1);
    step(1'b0, 4'd2);
    step(1'b1, 4'd3);
    tests++;
    if (dout !== 10'd999 || dout_vld !== 1'b1) begin
      fails++; $display("FAIL busy_max got dout=%0d vld=%b exp 999/1", dout, dout_vld);
    end
    idle(3);
    tests++;
    if (bcd !== 12'h0 || dig_cnt !== 2'd0 || ovf !== 1'b0) begin
      fails++; $display("FAIL busy_drop got bcd=%h cnt=%0d ovf=%b exp 0/0/0", bcd, dig_cnt, ovf);
    end
  endtask

  task automatic test_reset_mid_conv();
    key(4'd2); key(4'd5);
    step(1'b1, 4'hE);
    step(1'b0, 4'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dout !== 10'd0 || dout_vld !== 1'b0 || busy !== 1'b0 || bcd !== 12'h0 || dig_cnt !== 2'd0) begin
      fails++; $display("FAIL rst_mid got dout=%0d vld=%b busy=%b bcd=%h cnt=%0d exp all 0",
                        dout, dout_vld, busy, bcd, dig_cnt);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle(4);
    tests++;
    if (dout !== 10'd0) begin
      fails++; $display("FAIL rst_mid_hold got dout=%0d exp 0", dout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom % 2), 4'($urandom % 16));
    end
    step(1'b1, 4'hE);
    idle(6);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = 4'h0;
    din_vld = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_ovf();
    test_backspace();
    test_clear_ignored();
    test_busy_drop();
    test_reset_mid_conv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
